// File: rtl/bht_hist_pkg.sv
// Shared types and constants for the history-indexed branch history table.
package bht_hist_pkg;

    localparam int unsigned VLEN            = 39;
    localparam int unsigned INSTR_PER_FETCH = 2;
    localparam bit          RVC             = 1'b1;
    localparam int unsigned GHR_BITS_MAX    = 16;

    localparam int unsigned BHT_BIMODAL = 0;
    localparam int unsigned BHT_GSELECT = 1;
    localparam int unsigned BHT_GSHARE  = 2;

    typedef struct packed {
        logic valid;
        logic taken;
    } bht_prediction_t;

    typedef struct packed {
        logic                    valid;
        logic [VLEN-1:0]         pc;
        logic                    taken;
        logic [GHR_BITS_MAX-1:0] ghr;
    } bht_hist_update_t;

    typedef enum logic {
        BHT_IDLE,
        BHT_CLEAR
    } bht_state_e;

endpackage

// File: rtl/bht_hist_sat_counter.sv
// Saturating up/down counter used to train one BHT entry.
module bht_hist_sat_counter #(
    parameter int unsigned CTR_BITS = 2
) (
    input  logic [CTR_BITS-1:0] ctr_i,
    input  logic                up_i,
    output logic [CTR_BITS-1:0] ctr_o
);

    always_comb begin
        ctr_o = ctr_i;
        if (up_i) begin
            if (ctr_i != '1) ctr_o = ctr_i + CTR_BITS'(1);
        end else begin
            if (ctr_i != '0) ctr_o = ctr_i - CTR_BITS'(1);
        end
    end

endmodule

// File: rtl/bht_hist.sv
// Branch history table with bimodal/gselect/gshare indexing, carried-history
// training and a row-by-row flush sweep.
module bht_hist
    import bht_hist_pkg::*;
#(
    parameter int unsigned NR_ENTRIES = 1024,
    parameter int unsigned GHR_BITS   = 4,
    parameter int unsigned CTR_BITS   = 2,
    parameter int unsigned INDEX_MODE = 2
) (
    input  logic                                     clk_i,
    input  logic                                     rst_ni,
    input  logic                                     flush_i,
    input  logic                                     debug_mode_i,
    input  logic [VLEN-1:0]                          vpc_i,
    input  bht_hist_update_t                         bht_update_i,
    output bht_prediction_t [INSTR_PER_FETCH-1:0]    bht_prediction_o,
    output logic [GHR_BITS-1:0]                      ghr_o,
    output logic                                     busy_o
);

    localparam int unsigned NR_ROWS  = NR_ENTRIES / INSTR_PER_FETCH;
    localparam int unsigned ROW_BITS = $clog2(NR_ROWS);
    localparam int unsigned OFFSET   = RVC ? 1 : 2;
    localparam int unsigned BASE     = OFFSET + $clog2(INSTR_PER_FETCH);
    localparam int unsigned COL_W    = (INSTR_PER_FETCH > 1) ? $clog2(INSTR_PER_FETCH) : 1;
    localparam logic [COL_W-1:0]    COL_MASK = COL_W'(INSTR_PER_FETCH - 1);
    localparam logic [CTR_BITS-1:0] CTR_WEAK = {1'b1, {(CTR_BITS-1){1'b0}}};

    // Same function on both paths so an update lands on the entry that predicted.
    function automatic logic [ROW_BITS-1:0] row_idx(input logic [VLEN-1:0] p,
                                                    input logic [GHR_BITS-1:0] h);
        logic [ROW_BITS-1:0] pc_bits;
        pc_bits = ROW_BITS'(p >> BASE);
        if (INDEX_MODE == BHT_GSELECT)     return ROW_BITS'({pc_bits, h});
        else if (INDEX_MODE == BHT_GSHARE) return pc_bits ^ ROW_BITS'(h);
        else                               return pc_bits;
    endfunction

    function automatic logic [COL_W-1:0] col_idx(input logic [VLEN-1:0] p);
        return COL_W'(p >> OFFSET) & COL_MASK;
    endfunction

    logic [INSTR_PER_FETCH-1:0]               valid_q [NR_ROWS];
    logic [INSTR_PER_FETCH-1:0][CTR_BITS-1:0] ctr_q   [NR_ROWS];
    logic [GHR_BITS-1:0]                      ghr_q;
    logic [ROW_BITS-1:0]                      ptr_q;
    bht_state_e                               state_q, state_d;

    logic                busy;
    logic                upd_en;
    logic [ROW_BITS-1:0] rd_row, upd_row;
    logic [COL_W-1:0]    upd_col;
    logic [CTR_BITS-1:0] upd_ctr_cur, upd_ctr_new;
    logic                unused_ghr_hi;

    assign unused_ghr_hi = ^(bht_update_i.ghr >> GHR_BITS);

    // ---------------- sweep FSM ----------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= BHT_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            BHT_IDLE:  if (flush_i) state_d = BHT_CLEAR;
            BHT_CLEAR: if (!flush_i && ptr_q == ROW_BITS'(NR_ROWS - 1)) state_d = BHT_IDLE;
            default:   state_d = BHT_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == BHT_CLEAR);
    end

    assign busy_o = busy;

    // ---------------- pointer and history ----------------
    assign upd_en = bht_update_i.valid && !debug_mode_i && !busy;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= '0;
            ghr_q <= '0;
        end else if (flush_i) begin
            ptr_q <= '0;
            ghr_q <= '0;
        end else begin
            if (busy)   ptr_q <= ptr_q + ROW_BITS'(1);
            // Newest outcome enters at the LSB; the truncation drops the oldest.
            if (upd_en) ghr_q <= GHR_BITS'({ghr_q, bht_update_i.taken});
        end
    end

    assign ghr_o = ghr_q;

    // ---------------- update path ----------------
    assign upd_row     = row_idx(bht_update_i.pc, bht_update_i.ghr[GHR_BITS-1:0]);
    assign upd_col     = col_idx(bht_update_i.pc);
    assign upd_ctr_cur = ctr_q[upd_row][upd_col];

    bht_hist_sat_counter #(
        .CTR_BITS (CTR_BITS)
    ) i_sat_counter (
        .ctr_i (upd_ctr_cur),
        .up_i  (bht_update_i.taken),
        .ctr_o (upd_ctr_new)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int r = 0; r < NR_ROWS; r++) begin
                valid_q[r] <= '0;
                ctr_q[r]   <= '0;
            end
        end else if (busy) begin
            valid_q[ptr_q] <= '0;
            ctr_q[ptr_q]   <= {INSTR_PER_FETCH{CTR_WEAK}};
        end else if (upd_en) begin
            valid_q[upd_row][upd_col] <= 1'b1;
            ctr_q[upd_row][upd_col]   <= upd_ctr_new;
        end
    end

    // ---------------- prediction path ----------------
    assign rd_row = row_idx(vpc_i, ghr_q);

    always_comb begin
        bht_prediction_o = '0;
        for (int i = 0; i < INSTR_PER_FETCH; i++) begin
            bht_prediction_o[i].valid = valid_q[rd_row][i] & ~busy;
            bht_prediction_o[i].taken = ctr_q[rd_row][i][CTR_BITS-1];
        end
    end

endmodule

// File: tb/tb_bht_hist.sv
// Directed bench: gshare instance at defaults, gselect instance with a small table.
module tb_bht_hist;
    import bht_hist_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    // dut0: 1024 entries, GHR 4, gshare
    logic                                  flush0, dbg0, busy0;
    logic [VLEN-1:0]                       vpc0;
    bht_hist_update_t                      upd0;
    bht_prediction_t [INSTR_PER_FETCH-1:0] pred0;
    logic [3:0]                            ghr0;

    // dut1: 16 entries (8 rows), GHR 3 == ROW_BITS, gselect
    logic                                  flush1, dbg1, busy1;
    logic [VLEN-1:0]                       vpc1;
    bht_hist_update_t                      upd1;
    bht_prediction_t [INSTR_PER_FETCH-1:0] pred1;
    logic [2:0]                            ghr1;

    bht_hist dut0 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush0), .debug_mode_i(dbg0),
        .vpc_i(vpc0), .bht_update_i(upd0), .bht_prediction_o(pred0),
        .ghr_o(ghr0), .busy_o(busy0)
    );

    bht_hist #(.NR_ENTRIES(16), .GHR_BITS(3), .CTR_BITS(2), .INDEX_MODE(1)) dut1 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush1), .debug_mode_i(dbg1),
        .vpc_i(vpc1), .bht_update_i(upd1), .bht_prediction_o(pred1),
        .ghr_o(ghr1), .busy_o(busy1)
    );

    typedef struct {
        string tag;
        bit    d1;
        int    slot;
        logic  v;
        logic  t;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   ctr_m = 0;
    logic [3:0] ghr_m = '0;
    int   cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_pred(input string tag, input bit d1, input int slot,
                               input logic v, input logic t);
        exp_t e;
        e.tag = tag; e.d1 = d1; e.slot = slot; e.v = v; e.t = t;
        sb.push_back(e);
    endtask

    task automatic check_preds();
        #1;
        while (sb.size() > 0) begin
            exp_t e;
            bht_prediction_t o;
            e = sb.pop_front();
            o = e.d1 ? pred1[e.slot] : pred0[e.slot];
            tests++;
            assert ({o.valid, o.taken} === {e.v, e.t}) else begin
                fails++;
                $error("FAIL %s: got v=%b t=%b expected v=%b t=%b", e.tag, o.valid, o.taken, e.v, e.t);
            end
        end
    endtask

    // Inverse of gshare: fetch PC whose row equals 'row' under live history g.
    function automatic logic [VLEN-1:0] pc_for(input int row, input logic [3:0] g);
        return VLEN'((row ^ int'(g)) << 2);
    endfunction

    function automatic int sat(input int c, input logic t);
        if (t) return (c == 3) ? 3 : c + 1;
        return (c == 0) ? 0 : c - 1;
    endfunction

    task automatic upd0_go(input logic [VLEN-1:0] pc, input logic t, input logic [3:0] g, input logic dbg);
        upd0.valid = 1'b1; upd0.pc = pc; upd0.taken = t; upd0.ghr = GHR_BITS_MAX'(g); dbg0 = dbg;
        @(negedge clk);
        upd0.valid = 1'b0; dbg0 = 1'b0;
        if (!dbg) ghr_m = {ghr_m[2:0], t};
    endtask

    task automatic upd1_go(input logic [VLEN-1:0] pc, input logic t, input logic [2:0] g);
        upd1.valid = 1'b1; upd1.pc = pc; upd1.taken = t; upd1.ghr = GHR_BITS_MAX'(g);
        @(negedge clk);
        upd1.valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        flush0 = 0; dbg0 = 0; vpc0 = '0; upd0 = '0;
        flush1 = 0; dbg1 = 0; vpc1 = '0; upd1 = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // reset state
        chk("rst_ghr0", 32'(ghr0), 32'h0);
        chk("rst_busy0", 32'(busy0), 32'h0);
        chk("rst_ghr1", 32'(ghr1), 32'h0);
        chk("rst_busy1", 32'(busy1), 32'h0);
        vpc0 = VLEN'('h100);
        expect_pred("rst_s0", 0, 0, 1'b0, 1'b0);
        expect_pred("rst_s1", 0, 1, 1'b0, 1'b0);
        check_preds();

        // train pc 0x100 with ghr 0 three times: counter 0 -> 3
        repeat (3) begin
            upd0_go(VLEN'('h100), 1'b1, 4'h0, 1'b0);
            ctr_m = sat(ctr_m, 1'b1);
        end
        chk("ghr_after_train", 32'(ghr0), 32'h7);
        vpc0 = pc_for('h40, ghr_m);
        expect_pred("train_s0", 0, 0, 1'b1, 1'b1);
        expect_pred("train_s1", 0, 1, 1'b0, 1'b0);
        check_preds();

        // saturation at 0, then climb back
        for (int i = 0; i < 7; i++) begin
            logic t;
            t = (i >= 5);
            upd0_go(VLEN'('h100), t, 4'h0, 1'b0);
            ctr_m = sat(ctr_m, t);
            vpc0 = pc_for('h40, ghr_m);
            expect_pred($sformatf("sat_%0d", i), 0, 0, 1'b1, ctr_m >= 2);
            check_preds();
        end

        // history carry: predict under 0101, move GHR, then train with 0101
        upd0_go(VLEN'('h800), 1'b0, 4'h0, 1'b0);
        upd0_go(VLEN'('h800), 1'b1, 4'h0, 1'b0);
        upd0_go(VLEN'('h800), 1'b0, 4'h0, 1'b0);
        upd0_go(VLEN'('h800), 1'b1, 4'h0, 1'b0);
        chk("ghr_0101", 32'(ghr0), 32'h5);
        vpc0 = VLEN'('h200);
        expect_pred("carry_pre", 0, 0, 1'b0, 1'b0);
        check_preds();
        upd0_go(VLEN'('h800), 1'b1, 4'h0, 1'b0);
        upd0_go(VLEN'('h200), 1'b1, 4'h5, 1'b0);
        chk("ghr_0111", 32'(ghr0), 32'h7);
        vpc0 = pc_for('h85, ghr_m);
        expect_pred("carry_hit", 0, 0, 1'b1, 1'b0);
        check_preds();
        vpc0 = pc_for('h8B, ghr_m);
        expect_pred("carry_live_untouched", 0, 0, 1'b0, 1'b0);
        check_preds();

        // debug mode suppresses training and history shift
        upd0_go(VLEN'('h200), 1'b1, 4'h5, 1'b1);
        chk("dbg_ghr", 32'(ghr0), 32'(ghr_m));
        vpc0 = pc_for('h85, ghr_m);
        expect_pred("dbg_entry", 0, 0, 1'b1, 1'b0);
        check_preds();

        // same-cycle read/write of one entry shows the old value
        upd0.valid = 1'b1; upd0.pc = VLEN'('h200); upd0.taken = 1'b1; upd0.ghr = GHR_BITS_MAX'(4'h5);
        vpc0 = pc_for('h85, ghr_m);
        expect_pred("rw_same_cycle", 0, 0, 1'b1, 1'b0);
        check_preds();
        @(negedge clk);
        upd0.valid = 1'b0;
        ghr_m = {ghr_m[2:0], 1'b1};
        chk("ghr_1111", 32'(ghr0), 32'hF);
        vpc0 = pc_for('h85, ghr_m);
        expect_pred("rw_after", 0, 0, 1'b1, 1'b1);
        check_preds();

        // second column of the fetch row
        upd0_go(VLEN'('h102), 1'b1, 4'h0, 1'b0);
        vpc0 = pc_for('h40, ghr_m);
        expect_pred("col_s0", 0, 0, 1'b1, ctr_m >= 2);
        expect_pred("col_s1", 0, 1, 1'b1, 1'b0);
        check_preds();

        // gselect with GHR_BITS == ROW_BITS: row is the ghr field only
        upd1_go(VLEN'('h1000), 1'b1, 3'b101);
        upd1_go(VLEN'('h1234), 1'b1, 3'b101);
        upd1_go(VLEN'('h0), 1'b1, 3'b000);
        upd1_go(VLEN'('h0), 1'b0, 3'b000);
        upd1_go(VLEN'('h0), 1'b1, 3'b000);
        chk("gsel_ghr", 32'(ghr1), 32'h5);
        vpc1 = VLEN'('h7FC);
        expect_pred("gsel_s0", 1, 0, 1'b1, 1'b1);
        expect_pred("gsel_s1", 1, 1, 1'b0, 1'b0);
        check_preds();
        vpc1 = VLEN'('h0);
        expect_pred("gsel_pc0", 1, 0, 1'b1, 1'b1);
        check_preds();

        // flush sweep: 8 busy cycles, update in the middle is dropped
        flush1 = 1'b1;
        @(negedge clk);
        flush1 = 1'b0;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (!busy1) break;
            cnt++;
            if (cnt == 1) begin
                vpc1 = VLEN'('h0);
                expect_pred("busy_masks_valid", 1, 0, 1'b0, 1'b0);
                check_preds();
            end
            upd1.valid = (cnt == 5); upd1.pc = '0; upd1.taken = 1'b1; upd1.ghr = '0;
            @(negedge clk);
        end
        upd1.valid = 1'b0;
        chk("sweep_len", 32'(cnt), 32'd8);
        chk("sweep_ghr", 32'(ghr1), 32'h0);
        chk("sweep_done", 32'(busy1), 32'h0);
        vpc1 = VLEN'('h0);
        expect_pred("swept_s0", 1, 0, 1'b0, 1'b1);
        expect_pred("swept_s1", 1, 1, 1'b0, 1'b1);
        check_preds();

        // flush again at sweep cycle 5 restarts the sweep
        flush1 = 1'b1;
        @(negedge clk);
        flush1 = 1'b0;
        repeat (4) @(negedge clk);
        chk("restart_busy", 32'(busy1), 32'h1);
        flush1 = 1'b1;
        @(negedge clk);
        flush1 = 1'b0;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (!busy1) break;
            cnt++;
            @(negedge clk);
        end
        chk("restart_len", 32'(cnt), 32'd8);

        // asynchronous reset mid-sweep
        flush1 = 1'b1;
        @(negedge clk);
        flush1 = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("async_rst_busy", 32'(busy1), 32'h0);
        chk("async_rst_ghr0", 32'(ghr0), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        vpc1 = VLEN'('h0);
        expect_pred("rst_mid_s0", 1, 0, 1'b0, 1'b0);
        vpc0 = VLEN'('h100);
        expect_pred("rst_dut0_s0", 0, 0, 1'b0, 1'b0);
        check_preds();
        @(negedge clk);
        chk("rst_mid_idle", 32'(busy1), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
